// File: rtl/vga_stream_pkg.sv
// Shared types and layout helpers for the streamed video timing blocks.
package vga_stream_pkg;

  typedef enum logic [1:0] {
    DRAIN  = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } stream_state_t;

  localparam int PIX_W_DEFAULT = 24;

  function automatic int htotal(input int fp, input int pulse, input int bp, input int disp);
    return fp + pulse + bp + disp;
  endfunction

  function automatic int vtotal(input int fp, input int pulse, input int bp, input int disp);
    return fp + pulse + bp + disp;
  endfunction

  // Counter width that stays legal for degenerate one-entry ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel/row counters with registered sync, display-enable and coordinate decode.
// The unregistered decode of the current position is exported for same-cycle stream control.
module vga_timing_counter
  import vga_stream_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int XW     = $clog2(HDISP),
  parameter int YW     = $clog2(VDISP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          act_c,
  output logic          first_c,
  output logic          wrap_c,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  localparam int HT     = htotal(HFP, HPULSE, HBP, HDISP);
  localparam int VT     = vtotal(VFP, VPULSE, VBP, VDISP);
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int PW     = cnt_w(HT);
  localparam int RW     = cnt_w(VT);

  logic [PW-1:0] pix_q, pix_d;
  logic [RW-1:0] row_q, row_d;
  logic          h_end, v_end, hsync_c, vsync_c;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Line and frame order: front porch, sync, back porch, active.
  assign h_end   = (pix_q == PW'(HT - 1));
  assign v_end   = (row_q == RW'(VT - 1));
  assign wrap_c  = h_end && v_end;
  assign act_c   = (pix_q >= PW'(HSTART)) && (row_q >= RW'(VSTART));
  assign first_c = (pix_q == PW'(HSTART)) && (row_q == RW'(VSTART));
  assign hsync_c = (pix_q >= PW'(HFP)) && (pix_q < PW'(HFP + HPULSE));
  assign vsync_c = (row_q >= RW'(VFP)) && (row_q < RW'(VFP + VPULSE));

  always_comb begin
    pix_d = h_end ? '0 : pix_q + PW'(1);
    row_d = row_q;
    if (h_end) row_d = v_end ? '0 : row_q + RW'(1);
    hs_d    = hsync_c ? HS_POL : ~HS_POL;
    vs_d    = vsync_c ? VS_POL : ~VS_POL;
    blank_d = act_c;
    x_d     = act_c ? XW'(pix_q - PW'(HSTART)) : '0;
    y_d     = act_c ? YW'(row_q - RW'(VSTART)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q   <= '0;
      row_q   <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      pix_q   <= pix_d;
      row_q   <= row_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
  assign x     = x_q;
  assign y     = y_q;

endmodule

// File: rtl/vga_stream_timing.sv
// Video timing generator that pulls pixels from a valid/ready stream during the active area,
// dropping to fill colour and resynchronising on the stream's SOF tag after any error.
module vga_stream_timing
  import vga_stream_pkg::*;
#(
  parameter int               HDISP    = 800,
  parameter int               VDISP    = 480,
  parameter int               HFP      = 40,
  parameter int               HPULSE   = 48,
  parameter int               HBP      = 40,
  parameter int               VFP      = 13,
  parameter int               VPULSE   = 3,
  parameter int               VBP      = 29,
  parameter bit               HS_POL   = 1'b0,
  parameter bit               VS_POL   = 1'b0,
  parameter int               PIX_W    = PIX_W_DEFAULT,
  parameter logic [PIX_W-1:0] FILL_RGB = '0,
  parameter int               FCNT_W   = 16
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PIX_W-1:0]         s_data,
  input  logic                     s_sof,
  output logic                     hs,
  output logic                     vs,
  output logic                     blank,
  output logic [PIX_W-1:0]         rgb,
  output logic [$clog2(HDISP)-1:0] x,
  output logic [$clog2(VDISP)-1:0] y,
  input  logic                     clr_err,
  output logic                     underflow,
  output logic                     sof_err,
  output logic [FCNT_W-1:0]        frame_cnt
);

  logic act_c, first_c, wrap_c;

  vga_timing_counter #(
    .HDISP (HDISP),  .VDISP (VDISP),
    .HFP   (HFP),    .HPULSE(HPULSE), .HBP(HBP),
    .VFP   (VFP),    .VPULSE(VPULSE), .VBP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL),
    .XW    ($clog2(HDISP)),
    .YW    ($clog2(VDISP))
  ) u_cnt (
    .clk    (pixel_clk),
    .rst_n  (pixel_rst_n),
    .act_c  (act_c),
    .first_c(first_c),
    .wrap_c (wrap_c),
    .hs     (hs),
    .vs     (vs),
    .blank  (blank),
    .x      (x),
    .y      (y)
  );

  stream_state_t       state_q, state_d;
  logic                uf_c, sofe_c, take_c;
  logic                uf_q, uf_d, sofe_q, sofe_d;
  logic [PIX_W-1:0]    rgb_q, rgb_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;

  // Error detection only applies while this frame is owned and a pixel is due.
  assign uf_c   = (state_q == STREAM) && act_c && !s_valid;
  assign sofe_c = (state_q == STREAM) && act_c && s_valid && (s_sof != first_c);
  assign take_c = (state_q == STREAM) && s_valid && s_ready;

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) state_q <= DRAIN;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DRAIN:   if (s_valid && s_sof) state_d = ARMED;
      ARMED:   if (wrap_c) state_d = STREAM;
      STREAM:  if (uf_c || sofe_c) state_d = DRAIN;
      default: state_d = DRAIN;
    endcase
  end

  // A beat whose SOF tag disagrees with the position is refused so it is never lost;
  // ready is gated by reset so nothing is consumed while the block is held.
  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      DRAIN:   s_ready = !(s_valid && s_sof);
      ARMED:   s_ready = 1'b0;
      STREAM:  s_ready = act_c && (s_sof == first_c);
      default: s_ready = 1'b0;
    endcase
    s_ready = s_ready && pixel_rst_n;
  end

  always_comb begin
    rgb_d  = take_c ? s_data : FILL_RGB;
    uf_d   = uf_c   ? 1'b1 : (clr_err ? 1'b0 : uf_q);
    sofe_d = sofe_c ? 1'b1 : (clr_err ? 1'b0 : sofe_q);
    fcnt_d = wrap_c ? fcnt_q + FCNT_W'(1) : fcnt_q;
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      rgb_q  <= '0;
      uf_q   <= 1'b0;
      sofe_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      rgb_q  <= rgb_d;
      uf_q   <= uf_d;
      sofe_q <= sofe_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign rgb       = rgb_q;
  assign underflow = uf_q;
  assign sof_err   = sofe_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_vga_stream_timing.sv
// Bench for vga_stream_timing on a shrunken 16x8 raster: frame-level model plus pinned literals.
module tb_vga_stream_timing;

  localparam int HDISP = 16, VDISP = 8;
  localparam int HFP = 3, HPULSE = 4, HBP = 2;
  localparam int VFP = 2, VPULSE = 1, VBP = 2;
  localparam int HT  = HDISP + HFP + HPULSE + HBP;   // 25
  localparam int VT  = VDISP + VFP + VPULSE + VBP;   // 13
  localparam int HS0 = HFP + HPULSE + HBP;           // 9
  localparam int VS0 = VFP + VPULSE + VBP;           // 5
  localparam int F   = HT * VT;                      // 325
  localparam int XW  = $clog2(HDISP);
  localparam int YW  = $clog2(VDISP);
  localparam logic [23:0] FILL = 24'h000000;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst_n = 1'b0;
  logic          s_valid = 1'b0, s_sof = 1'b0, clr_err = 1'b0;
  logic          s_ready;
  logic [23:0]   s_data = '0, rgb;
  logic          hs, vs, blank, underflow, sof_err;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [15:0]   frame_cnt;

  always #5 pixel_clk = ~pixel_clk;

  vga_stream_timing #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0),
    .PIX_W(24), .FILL_RGB(FILL), .FCNT_W(16)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .hs(hs), .vs(vs), .blank(blank), .rgb(rgb), .x(x), .y(y),
    .clr_err(clr_err), .underflow(underflow), .sof_err(sof_err), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix_word(input int px, input int py);
    logic [7:0] a, b;
    a = py[7:0];
    b = px[7:0];
    return {a, b, 8'hA5};
  endfunction

  // Model state: counter index being driven, frame ownership, sticky flags, frame count.
  int   cyc = 0, m_fcnt = 0;
  bit   own = 0, m_uf = 0, m_se = 0;
  bit   chk_en = 0;
  logic e_hs = 1, e_vs = 1, e_blank = 0;
  int   e_x = 0, e_y = 0, e_n = 0;
  logic [23:0] e_rgb = '0;
  // Upstream source: beat index within the source frame, pending junk beats.
  int   src_k = 0, src_junk = 0;
  bit   junk_arm = 0;
  int   drop_n = -1, clr_n = -1;
  int   t_hs = 0, t_vs = 0, t_bl = 0;

  task automatic model_reset();
    cyc = 0; m_fcnt = 0; own = 0; m_uf = 0; m_se = 0;
    drop_n = -1; clr_n = -1;
  endtask

  // One pixel clock: drive at negedge, predict post-edge outputs, advance source on handshake.
  task automatic step();
    int p, r;
    bit act, first, last, hsof, uf, se;
    p = cyc % HT;
    r = (cyc / HT) % VT;
    hsof    = (src_junk == 0) && (src_k == 0);
    s_valid = (cyc != drop_n);
    s_sof   = hsof;
    s_data  = (src_junk > 0) ? 24'h5A5A5A : pix_word(src_k % HDISP, src_k / HDISP);
    clr_err = (cyc == clr_n);
    #1;
    act   = (p >= HS0) && (r >= VS0);
    first = (p == HS0) && (r == VS0);
    last  = (p == HT - 1) && (r == VT - 1);
    e_n     = cyc;
    e_hs    = !((p >= HFP) && (p < HFP + HPULSE));
    e_vs    = !((r >= VFP) && (r < VFP + VPULSE));
    e_blank = act;
    e_x     = act ? p - HS0 : 0;
    e_y     = act ? r - VS0 : 0;
    e_rgb   = FILL;
    uf = 0; se = 0;
    if (own && act) begin
      uf = !s_valid;
      se = s_valid && (hsof != first);
      if (uf || se) own = 0;
      else e_rgb = pix_word(e_x, e_y);
    end
    m_uf = uf ? 1'b1 : (clr_err ? 1'b0 : m_uf);
    m_se = se ? 1'b1 : (clr_err ? 1'b0 : m_se);
    // A frame is streamed if the previous one ran clean or the SOF beat is already waiting.
    if (last) begin
      m_fcnt++;
      own = own || (s_valid && hsof);
    end
    if (s_valid && s_ready) begin
      if (src_junk > 0) src_junk--;
      else begin
        src_k++;
        if (src_k == HDISP * VDISP) begin
          src_k = 0;
          if (junk_arm) begin src_junk = 3; junk_arm = 0; end
        end
      end
    end
    chk_en = 1;
    @(negedge pixel_clk);
    cyc++;
  endtask

  always @(negedge pixel_clk) begin
    if (chk_en) begin
      chk("hs",        32'(hs),        32'(e_hs));
      chk("vs",        32'(vs),        32'(e_vs));
      chk("blank",     32'(blank),     32'(e_blank));
      chk("x",         32'(x),         e_x);
      chk("y",         32'(y),         e_y);
      chk("rgb",       32'(rgb),       32'(e_rgb));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("sof_err",   32'(sof_err),   32'(m_se));
      chk("frame_cnt", 32'(frame_cnt), m_fcnt % 65536);
      if (e_n < F) begin
        if (hs == 1'b0) t_hs++;
        if (vs == 1'b0) t_vs++;
        if (blank == 1'b1) t_bl++;
      end
    end
  end

  localparam int DROP_AT = 4 * F + (VS0 + 3) * HT + HS0 + 5;
  localparam int CLR_AT  = 8 * F + 3;
  localparam int RST_AT  = 8 * F + (VS0 + 2) * HT + HS0 + 3;

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"},    32'(hs),        32'd1);
    chk({tag, "_vs"},    32'(vs),        32'd1);
    chk({tag, "_blank"}, 32'(blank),     32'd0);
    chk({tag, "_rgb"},   32'(rgb),       32'd0);
    chk({tag, "_x"},     32'(x),         32'd0);
    chk({tag, "_y"},     32'(y),         32'd0);
    chk({tag, "_uf"},    32'(underflow), 32'd0);
    chk({tag, "_se"},    32'(sof_err),   32'd0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready),   32'd0);
  endtask

  initial begin
    pixel_rst_n = 1'b0;
    s_valid = 1'b1; s_sof = 1'b0; s_data = 24'h123456; clr_err = 1'b0;
    repeat (3) @(negedge pixel_clk);
    #1;
    chk_reset_vals("por");
    @(negedge pixel_clk);
    model_reset();
    drop_n = DROP_AT;
    clr_n  = CLR_AT;
    pixel_rst_n = 1'b1;

    for (int i = 0; i < RST_AT; i++) begin
      if (cyc == 5 * F) junk_arm = 1;
      step();
      if (cyc == F + 2) begin
        chk("hs_low_per_frame",  t_hs, 32'd52);
        chk("vs_low_per_frame",  t_vs, 32'd25);
        chk("blank_hi_per_frame", t_bl, 32'd128);
      end
      if (cyc == F + (VS0 + 3) * HT + HS0 + 5 + 1) chk("lit_rgb_f1_x5y3", 32'(rgb), 32'h0305A5);
      if (cyc == 5 * F) chk("lit_fcnt_5", 32'(frame_cnt), 32'd5);
      if (cyc == DROP_AT + 1) begin
        chk("lit_underflow", 32'(underflow), 32'd1);
        chk("lit_fill_on_drop", 32'(rgb), 32'd0);
      end
      if (cyc == 5 * F + VS0 * HT + HS0 + 1) chk("lit_rgb_f5_resume", 32'(rgb), 32'h0000A5);
      if (cyc == 6 * F + VS0 * HT + HS0 + 1) chk("lit_sof_err", 32'(sof_err), 32'd1);
      if (cyc == 7 * F + VS0 * HT + HS0 + 2) chk("lit_rgb_f7_resume", 32'(rgb), 32'h0001A5);
      if (cyc == CLR_AT) begin
        chk("lit_uf_before_clr", 32'(underflow), 32'd1);
        chk("lit_se_before_clr", 32'(sof_err),   32'd1);
      end
      if (cyc == CLR_AT + 1) begin
        chk("lit_uf_cleared", 32'(underflow), 32'd0);
        chk("lit_se_cleared", 32'(sof_err),   32'd0);
      end
    end

    // Mid-active-line reset: outputs must drop to reset values without waiting for a clock.
    chk("lit_blank_before_rst", 32'(blank), 32'd1);
    chk_en = 0;
    pixel_rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge pixel_clk);
    #1;
    chk("mid_hold_ready", 32'(s_ready), 32'd0);
    @(negedge pixel_clk);
    model_reset();
    pixel_rst_n = 1'b1;

    for (int i = 0; i < 2 * F + 3; i++) begin
      step();
      if (cyc == 1) chk("lit_restart_hs", 32'(hs), 32'd1);
      if (cyc == F + (VS0 + 2) * HT + HS0 + 3 + 1) chk("lit_rgb_post_rst", 32'(rgb), 32'h0203A5);
      if (cyc == 2 * F) chk("lit_fcnt_post_rst", 32'(frame_cnt), 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
